// File: rtl/spi_slave_if.sv
// Bus bundle between the SPI target endpoint and its surroundings: the pad-side
// serial lines plus the core-side transmit handshake and receive strobe.
interface spi_slave_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              underrun;

    modport slave (
        input  sclk, ss_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
    );

    modport master (
        output sclk, ss_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
    );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI target: oversampled sclk/ss_n/mosi, one-entry transmit holding buffer.
// States: IDLE = not selected, miso parked low | ACTIVE = selected, shifting words.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_slave_if.slave  spi
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                   state_q;
    logic [SYNC_STAGES-1:0]   sclk_sync_q;
    logic [SYNC_STAGES-1:0]   ss_sync_q;
    logic [SYNC_STAGES-1:0]   mosi_sync_q;
    logic                     sclk_prev_q;
    logic                     ss_prev_q;
    logic [DATA_W-1:0]        tx_shift_q;
    logic [DATA_W-2:0]        rx_shift_q;
    logic [CNT_W-1:0]         bit_cnt_q;
    logic                     reload_q;
    logic [DATA_W-1:0]        rx_data_q;
    logic                     rx_valid_q;
    logic                     underrun_q;
    logic [DATA_W-1:0]        buf_q;
    logic [DATA_W-1:0]        buf_d;
    logic                     buf_full_q;
    logic                     buf_full_d;

    logic                     sclk_s;
    logic                     ss_s;
    logic                     mosi_s;
    logic                     sclk_rise;
    logic                     sclk_fall;
    logic                     ss_fall;
    logic                     load_evt;
    logic [DATA_W-1:0]        load_word;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;

    // Synchronizers reset to the idle bus levels so a select held low across
    // reset release is still seen as a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    // A load samples the buffer before any same-cycle write lands.
    always_comb begin
        load_evt   = 1'b0;
        if (state_q == IDLE) begin
            load_evt = ss_fall;
        end else begin
            load_evt = ~ss_s & sclk_fall & reload_q;
        end
        load_word  = buf_full_q ? buf_q : '0;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (load_evt) begin
            buf_full_d = 1'b0;
        end
        if (spi.tx_valid && !buf_full_q) begin
            buf_d      = spi.tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            reload_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_q    <= ACTIVE;
                        tx_shift_q <= load_word;
                        underrun_q <= ~buf_full_q;
                        rx_shift_q <= '0;
                        bit_cnt_q  <= '0;
                        reload_q   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (ss_s) begin
                        // Deselect aborts the word in flight on both directions.
                        state_q    <= IDLE;
                        tx_shift_q <= '0;
                        rx_shift_q <= '0;
                        bit_cnt_q  <= '0;
                        reload_q   <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift_q <= {rx_shift_q[DATA_W-3:0], mosi_s};
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_q  <= {rx_shift_q, mosi_s};
                            rx_valid_q <= 1'b1;
                            bit_cnt_q  <= '0;
                            reload_q   <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (reload_q) begin
                            tx_shift_q <= load_word;
                            underrun_q <= ~buf_full_q;
                            reload_q   <= 1'b0;
                        end else begin
                            tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi.miso     = tx_shift_q[DATA_W-1];
    assign spi.miso_oe  = (state_q == ACTIVE);
    assign spi.busy     = (state_q == ACTIVE);
    assign spi.tx_ready = ~buf_full_q;
    assign spi.rx_data  = rx_data_q;
    assign spi.rx_valid = rx_valid_q;
    assign spi.underrun = underrun_q;
endmodule
